// File: rtl/cpu_io_bridge_pkg.sv
// Shared constants and status packing for the core-to-host I/O bridge.
// Status word layout: {overflow, underflow, rx_nonempty, tx_full}.
package io_bridge_pkg;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = $clog2(DEPTH);

  localparam int STAT_OVF  = 3;
  localparam int STAT_UNF  = 2;
  localparam int STAT_RXNE = 1;
  localparam int STAT_TXF  = 0;

  function automatic logic [3:0] pack_status(
    input logic ovf,
    input logic unf,
    input logic rxne,
    input logic txf
  );
    logic [3:0] s;
    s            = '0;
    s[STAT_OVF]  = ovf;
    s[STAT_UNF]  = unf;
    s[STAT_RXNE] = rxne;
    s[STAT_TXF]  = txf;
    return s;
  endfunction

endpackage

// File: rtl/cpu_io_bridge_if.sv
// Core-side strobes and host-side valid/ready channels of the I/O bridge.
// The bridge takes the slave view; the core/host environment takes the master view.
interface cpu_io_bridge_if #(
  parameter int DATA_W = io_bridge_pkg::DATA_W
);
  logic [DATA_W-1:0] cpu_out_data;
  logic              cpu_out_write;
  logic              cpu_in_read;
  logic [DATA_W-1:0] cpu_in_data;
  logic [3:0]        cpu_status;
  logic [DATA_W-1:0] host_tx_data;
  logic              host_tx_valid;
  logic              host_tx_ready;
  logic [DATA_W-1:0] host_rx_data;
  logic              host_rx_valid;
  logic              host_rx_ready;

  modport master (
    output cpu_out_data, cpu_out_write, cpu_in_read,
    output host_tx_ready, host_rx_data, host_rx_valid,
    input  cpu_in_data, cpu_status, host_tx_data, host_tx_valid, host_rx_ready
  );

  modport slave (
    input  cpu_out_data, cpu_out_write, cpu_in_read,
    input  host_tx_ready, host_rx_data, host_rx_valid,
    output cpu_in_data, cpu_status, host_tx_data, host_tx_valid, host_rx_ready
  );
endinterface

// File: rtl/cpu_io_bridge_fifo.sv
// Show-ahead synchronous FIFO; push visible at head one cycle later, flags decode the registered count.
// Caller qualifies push/pop: no internal overflow/underflow protection.
module sync_fifo #(
  parameter int  DATA_W = io_bridge_pkg::DATA_W,
  parameter int  DEPTH  = io_bridge_pkg::DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (!push && pop) count <= count - CNT_ONE;
    end
  end

  // Storage is left unreset; the count decides what is meaningful.
  always_ff @(posedge CLK) begin
    if (push && !Reset) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/cpu_io_bridge.sv
// Core/host I/O bridge: TX FIFO (core->host) and RX FIFO (host->core), 1-cycle push-to-head latency.
// host_tx_valid/host_rx_ready come from registered counts; overflow drops, underflow ignored, both sticky.
module cpu_io_bridge
  import io_bridge_pkg::*;
(
  input logic            CLK,
  input logic            Reset,
  cpu_io_bridge_if.slave bus
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] tx_head, rx_head;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic [ADDR_W:0]   tx_count, rx_count;
  logic              tx_push, tx_pop, rx_push, rx_pop;
  logic              ovf_q, unf_q;

  // A full TX FIFO still accepts a write when the host drains the head in the same cycle.
  assign tx_pop  = !tx_empty && bus.host_tx_ready;
  assign tx_push = bus.cpu_out_write && (!tx_full || tx_pop);
  assign rx_push = bus.host_rx_valid && !rx_full;
  assign rx_pop  = bus.cpu_in_read && !rx_empty;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
    .CLK       (CLK),
    .Reset     (Reset),
    .push      (tx_push),
    .push_data (bus.cpu_out_data),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
    .CLK       (CLK),
    .Reset     (Reset),
    .push      (rx_push),
    .push_data (bus.host_rx_data),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.cpu_out_write && tx_full && !tx_pop) ovf_q <= 1'b1;
      if (bus.cpu_in_read && rx_empty)             unf_q <= 1'b1;
    end
  end

  assign bus.host_tx_data  = tx_head;
  assign bus.host_tx_valid = !tx_empty;
  assign bus.host_rx_ready = !rx_full;
  assign bus.cpu_in_data   = rx_empty ? '0 : rx_head;
  assign bus.cpu_status    = pack_status(ovf_q, unf_q, (rx_count != '0), (tx_count == FULL_CNT));

endmodule

// File: tb/tb_cpu_io_bridge.sv
// Directed bench for cpu_io_bridge with TX/RX scoreboards checked by negedge monitors.
module tb_cpu_io_bridge;
  import io_bridge_pkg::*;

  logic CLK = 1'b0;
  logic Reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [15:0] tx_q[$];
  logic [15:0] rx_q[$];

  cpu_io_bridge_if #(.DATA_W(DATA_W)) bif ();

  cpu_io_bridge dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bif.slave)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] d, input bit accept);
    bif.cpu_out_data  = d;
    bif.cpu_out_write = 1'b1;
    if (accept) tx_q.push_back(d);
    tick();
    bif.cpu_out_write = 1'b0;
  endtask

  task automatic host_push(input logic [15:0] d, input bit accept);
    bif.host_rx_data  = d;
    bif.host_rx_valid = 1'b1;
    if (accept) rx_q.push_back(d);
    tick();
    bif.host_rx_valid = 1'b0;
  endtask

  task automatic cpu_read();
    bif.cpu_in_read = 1'b1;
    tick();
    bif.cpu_in_read = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tx_q.delete();
    rx_q.delete();
  endtask

  // A handshake seen at negedge completes on the next rising edge.
  always @(negedge CLK) begin
    if (!Reset && bif.host_tx_valid && bif.host_tx_ready)
      check("tx_order", {16'h0, bif.host_tx_data},
            (tx_q.size() > 0) ? {16'h0, tx_q.pop_front()} : 32'hDEAD0000);
    if (!Reset && bif.cpu_in_read && bif.cpu_status[STAT_RXNE])
      check("rx_order", {16'h0, bif.cpu_in_data},
            (rx_q.size() > 0) ? {16'h0, rx_q.pop_front()} : 32'hDEAD0000);
  end

  initial begin
    bif.cpu_out_data  = '0;
    bif.cpu_out_write = 1'b0;
    bif.cpu_in_read   = 1'b0;
    bif.host_tx_ready = 1'b0;
    bif.host_rx_data  = '0;
    bif.host_rx_valid = 1'b0;
    tick();
    do_reset();

    check("rst_status", bif.cpu_status, 4'b0000);
    check("rst_tx_valid", bif.host_tx_valid, 1'b0);
    check("rst_rx_ready", bif.host_rx_ready, 1'b1);
    check("rst_in_data", bif.cpu_in_data, 16'h0000);

    // Streaming TX with the host always ready
    bif.host_tx_ready = 1'b1;
    cpu_write(16'h1111, 1'b1);
    check("t1_valid", bif.host_tx_valid, 1'b1);
    check("t1_d0", bif.host_tx_data, 16'h1111);
    cpu_write(16'h2222, 1'b1);
    check("t1_d1", bif.host_tx_data, 16'h2222);
    cpu_write(16'h3333, 1'b1);
    check("t1_d2", bif.host_tx_data, 16'h3333);
    tick();
    check("t1_drop_valid", bif.host_tx_valid, 1'b0);

    // TX overflow with the host stalled
    bif.host_tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cpu_write(16'hA000 + 16'(i), (i < 4));
      if (i == 3) begin
        check("t2_full", bif.cpu_status[STAT_TXF], 1'b1);
        check("t2_no_ovf_yet", bif.cpu_status[STAT_OVF], 1'b0);
      end
    end
    check("t2_ovf", bif.cpu_status[STAT_OVF], 1'b1);
    check("t2_stable", bif.host_tx_data, 16'hA000);
    bif.host_tx_ready = 1'b1;
    repeat (6) tick();
    check("t2_drained", tx_q.size(), 0);
    check("t2_valid_low", bif.host_tx_valid, 1'b0);

    // RX show-ahead reads
    host_push(16'h00AA, 1'b1);
    host_push(16'h00BB, 1'b1);
    check("t3_rxne", bif.cpu_status[STAT_RXNE], 1'b1);
    check("t3_head0", bif.cpu_in_data, 16'h00AA);
    cpu_read();
    check("t3_head1", bif.cpu_in_data, 16'h00BB);
    cpu_read();
    check("t3_empty_data", bif.cpu_in_data, 16'h0000);
    check("t3_rxne_low", bif.cpu_status[STAT_RXNE], 1'b0);

    // RX underflow is sticky and leaves the pointers alone
    check("t4_no_unf_yet", bif.cpu_status[STAT_UNF], 1'b0);
    cpu_read();
    check("t4_unf", bif.cpu_status[STAT_UNF], 1'b1);
    check("t4_data_zero", bif.cpu_in_data, 16'h0000);
    host_push(16'h0055, 1'b1);
    check("t4_head_ok", bif.cpu_in_data, 16'h0055);
    cpu_read();
    repeat (3) tick();
    check("t4_unf_sticky", bif.cpu_status[STAT_UNF], 1'b1);

    // RX fill to full, extra offer refused
    for (int i = 0; i < 4; i++) host_push(16'h5A00 + 16'(i), 1'b1);
    check("rx_full_ready", bif.host_rx_ready, 1'b0);
    host_push(16'h5AFF, 1'b0);
    for (int i = 0; i < 4; i++) cpu_read();
    check("rx_drained", rx_q.size(), 0);
    check("rx_ready_back", bif.host_rx_ready, 1'b1);

    // TX full with simultaneous push/pop
    do_reset();
    check("t5_rst_status", bif.cpu_status, 4'b0000);
    bif.host_tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) cpu_write(16'hB000 + 16'(i), 1'b1);
    check("t5_full", bif.cpu_status[STAT_TXF], 1'b1);
    bif.host_tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_write(16'hC000 + 16'(i), 1'b1);
      check("t5_still_full", bif.cpu_status[STAT_TXF], 1'b1);
    end
    repeat (6) tick();
    check("t5_no_ovf", bif.cpu_status[STAT_OVF], 1'b0);
    check("t5_drained", tx_q.size(), 0);

    // Reset during an RX offer discards everything
    do_reset();
    host_push(16'hD001, 1'b1);
    host_push(16'hD002, 1'b1);
    check("t6_rxne", bif.cpu_status[STAT_RXNE], 1'b1);
    bif.host_rx_data  = 16'hD0FF;
    bif.host_rx_valid = 1'b1;
    do_reset();
    bif.host_rx_valid = 1'b0;
    check("t6_status", bif.cpu_status, 4'b0000);
    check("t6_rx_ready", bif.host_rx_ready, 1'b1);
    check("t6_in_data", bif.cpu_in_data, 16'h0000);
    tick();
    check("t6_not_stored", bif.cpu_status[STAT_RXNE], 1'b0);
    check("t6_in_data2", bif.cpu_in_data, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
